ysyx_25040111_clint: RTL and testbench

Core-local timer (CLINT) exposed as a read-only AXI4 slave. It sits directly downstream of the core's LSU master port: loads whose address falls in the CLINT window are routed to it. It answers single and burst reads of the 64-bit `mtime` counter. Writes are not routed here.

---
 rtl/ysyx_25040111_clint_pkg.sv | 50 +++++
 rtl/ysyx_25040111_clint_tick.sv | 36 +++
 rtl/ysyx_25040111_clint.sv | 114 +++++++++++
 tb/tb_ysyx_25040111_clint.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_clint_pkg.sv
// Shared constants and the beat decoder for the read-only CLINT AXI slave.
package ysyx_25040111_clint_pkg;

  localparam logic [31:0] CLINT_BASE  = 32'h0200_0000;
  localparam logic [15:0] MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] MTIME_HI    = 16'hBFFC;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;

  localparam logic [2:0]  SIZE_WORD   = 3'b010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } beat_t;

  // Only word beats of FIXED/INCR bursts hitting one of the two mtime words
  // return data; everything else is an error beat with zero data.
  function automatic beat_t beat_decode(input logic [31:0] base,
                                        input logic [31:0] addr,
                                        input logic [2:0]  size,
                                        input logic [1:0]  burst,
                                        input logic [63:0] snap);
    beat_t b;
    b.resp = RESP_SLVERR;
    b.data = '0;
    if ((addr[31:16] == base[31:16]) && (size == SIZE_WORD) &&
        ((burst == BURST_FIXED) || (burst == BURST_INCR))) begin
      if (addr[15:0] == MTIME_LO) begin
        b.resp = RESP_OKAY;
        b.data = snap[31:0];
      end else if (addr[15:0] == MTIME_HI) begin
        b.resp = RESP_OKAY;
        b.data = snap[63:32];
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/ysyx_25040111_clint_tick.sv
// Free-running 64-bit mtime counter; YSYX_25040111_CLINT_DIV_EN adds a 0..DIV-1 prescaler.
module ysyx_25040111_clint_tick #(
  parameter int DIV = 16
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] mtime
);

  logic [63:0] mtime_q;
  logic        tick;

`ifdef YSYX_25040111_CLINT_DIV_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  logic [PW-1:0] pre_q;

  assign tick = (pre_q == PW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end
`else
  // Prescaler absent: any legal DIV (>= 1) makes this a tick every cycle.
  assign tick = (DIV > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset)     mtime_q <= '0;
    else if (tick) mtime_q <= mtime_q + 64'd1;
  end

  assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_25040111_clint.sv
// Read-only AXI4 CLINT: IDLE/READ FSM serving mtime beats from a per-burst snapshot.
// Optional prescaler in the tick sub-module is enabled by YSYX_25040111_CLINT_DIV_EN.
// Handshake: a channel transfers on the rising edge where valid & ready are both high;
// rvalid and all R payload hold steady until that transfer.
module ysyx_25040111_clint
  import ysyx_25040111_clint_pkg::*;
#(
  parameter logic [31:0] BASE = CLINT_BASE,
  parameter int          DIV  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  output logic [63:0] mtime
);

  logic [63:0]  mtime_w;
  clint_state_e state_q;
  logic [31:0]  addr_q;
  logic [31:0]  addr_nxt;
  logic [7:0]   cnt_q;
  logic [2:0]   size_q;
  logic [1:0]   burst_q;
  logic [63:0]  snap_q;
  logic         ar_fire;
  logic         r_fire;
  beat_t        ar_beat;
  beat_t        nxt_beat;

  ysyx_25040111_clint_tick #(.DIV(DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .mtime (mtime_w)
  );

  assign mtime    = mtime_w;
  assign ar_fire  = arvalid & arready;
  assign r_fire   = rvalid & rready;
  assign addr_nxt = (burst_q == BURST_INCR) ? addr_q + 32'd4 : addr_q;

  // The first beat decodes against live mtime, which is exactly what the snapshot captures.
  assign ar_beat  = beat_decode(BASE, araddr, arsize, arburst, mtime_w);
  assign nxt_beat = beat_decode(BASE, addr_nxt, size_q, burst_q, snap_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rid     <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          arready <= 1'b1;
          if (ar_fire) begin
            state_q <= ST_READ;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            rdata   <= ar_beat.data;
            rresp   <= ar_beat.resp;
            rid     <= arid;
            addr_q  <= araddr;
            cnt_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            snap_q  <= mtime_w;
          end
        end
        ST_READ: begin
          if (r_fire) begin
            if (rlast) begin
              // arready comes back only after the last beat has left.
              state_q <= ST_IDLE;
              arready <= 1'b1;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              rdata   <= '0;
              rresp   <= '0;
            end else begin
              addr_q  <= addr_nxt;
              cnt_q   <= cnt_q - 8'd1;
              rlast   <= (cnt_q == 8'd1);
              rdata   <= nxt_beat.data;
              rresp   <= nxt_beat.resp;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_clint.sv
// Directed bench for the CLINT: reset, mtime reads, error windows, stalls, mid-burst reset.
module tb_ysyx_25040111_clint;
  import ysyx_25040111_clint_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          DIV  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic [63:0] mtime;

  always #5 clock = ~clock;

  ysyx_25040111_clint #(.BASE(BASE), .DIV(DIV)) dut (
    .clock   (clock),
    .reset   (reset),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .arid    (arid),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rid     (rid),
    .mtime   (mtime)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  resp_q[$];
  logic [63:0] snap_exp;

  // Reference mtime: counts ticks, can be preloaded to follow a forced counter value.
  logic [63:0] m_mtime = '0;
  int          m_pre   = 0;
  logic        m_load  = 1'b0;
  logic [63:0] m_load_val = '0;
  logic        m_tick;

`ifdef YSYX_25040111_CLINT_DIV_EN
  assign m_tick = (m_pre == DIV - 1);
`else
  assign m_tick = 1'b1;
`endif

  always @(posedge clock) begin
    if (reset) begin
      m_mtime <= '0;
      m_pre   <= 0;
    end else begin
      m_mtime <= (m_load ? m_load_val : m_mtime) + {63'd0, m_tick};
      m_pre   <= m_tick ? 0 : m_pre + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the AR handshake edge.
  task automatic ar_send(input logic [31:0] addr, input logic [3:0] id,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst);
    int n;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("ar_ready_wait", {63'd0, arready}, 64'd1);
    arvalid  = 1'b1;
    araddr   = addr;
    arid     = id;
    arlen    = len;
    arsize   = size;
    arburst  = burst;
    snap_exp = m_mtime;
    @(posedge clock);
    @(negedge clock);
    arvalid  = 1'b0;
    check("ar_to_r_latency", {63'd0, rvalid}, 64'd1);
  endtask

  task automatic r_collect(input logic [3:0] id, input int beats, input bit stall);
    logic [31:0] d0;
    logic [1:0]  r0;
    logic        l0;
    logic [31:0] ed;
    logic [1:0]  er;
    for (int i = 0; i < beats; i++) begin
      if (stall) begin
        rready = 1'b0;
        d0 = rdata;
        r0 = rresp;
        l0 = rlast;
        @(posedge clock);
        @(negedge clock);
        check("stall_rvalid", {63'd0, rvalid}, 64'd1);
        check("stall_rdata", {32'd0, rdata}, {32'd0, d0});
        check("stall_rresp", {62'd0, rresp}, {62'd0, r0});
        check("stall_rlast", {63'd0, rlast}, {63'd0, l0});
        check("stall_arready", {63'd0, arready}, 64'd0);
      end
      rready = 1'b1;
      ed = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      er = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b11;
      check("beat_rvalid", {63'd0, rvalid}, 64'd1);
      check("beat_rdata", {32'd0, rdata}, {32'd0, ed});
      check("beat_rresp", {62'd0, rresp}, {62'd0, er});
      check("beat_rlast", {63'd0, rlast}, {63'd0, (i == beats - 1)});
      check("beat_rid", {60'd0, rid}, {60'd0, id});
      check("beat_arready", {63'd0, arready}, 64'd0);
      @(posedge clock);
      @(negedge clock);
    end
    rready = 1'b0;
    check("end_rvalid", {63'd0, rvalid}, 64'd0);
    check("end_arready", {63'd0, arready}, 64'd1);
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_arready", {63'd0, arready}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_rlast", {63'd0, rlast}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_rresp", {62'd0, rresp}, 64'd0);
    check("rst_rid", {60'd0, rid}, 64'd0);
    check("rst_mtime", mtime, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_arready", {63'd0, arready}, 64'd1);
    check("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
    repeat (39) @(negedge clock);
`ifdef YSYX_25040111_CLINT_DIV_EN
    check("mtime_after_40", mtime, 64'd10);
`else
    check("mtime_after_40", mtime, 64'd40);
`endif

    // Single read of mtime low word.
    ar_send(BASE + 32'h0000_BFF8, 4'h5, 8'd0, SIZE_WORD, BURST_INCR);
    exp_q.push_back(snap_exp[31:0]); resp_q.push_back(RESP_OKAY);
    r_collect(4'h5, 1, 1'b0);

    // Carry out of bit 31: both words come from one sample.
    force dut.u_tick.mtime_q = 64'h0000_0000_FFFF_FFFF;
    m_load_val = 64'h0000_0000_FFFF_FFFF;
    m_load = 1'b1;
    #1 release dut.u_tick.mtime_q;
    ar_send(BASE + 32'h0000_BFF8, 4'h3, 8'd1, SIZE_WORD, BURST_INCR);
    m_load = 1'b0;
    check("carry_mtime", mtime, m_mtime);
    exp_q.push_back(32'hFFFF_FFFF); resp_q.push_back(RESP_OKAY);
    exp_q.push_back(32'h0000_0000); resp_q.push_back(RESP_OKAY);
    r_collect(4'h3, 2, 1'b0);

    // Unmapped offset and out-of-window address.
    ar_send(BASE, 4'h1, 8'd0, SIZE_WORD, BURST_INCR);
    exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    r_collect(4'h1, 1, 1'b0);
    ar_send(32'h0300_0000, 4'h2, 8'd0, SIZE_WORD, BURST_INCR);
    exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    r_collect(4'h2, 1, 1'b0);

    // FIXED 4-beat read of the high word with rready toggling.
    ar_send(BASE + 32'h0000_BFFC, 4'h7, 8'd3, SIZE_WORD, BURST_FIXED);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(snap_exp[63:32]); resp_q.push_back(RESP_OKAY);
    end
    r_collect(4'h7, 4, 1'b1);

    // INCR from the high word steps past the map into an error beat.
    ar_send(BASE + 32'h0000_BFFC, 4'h9, 8'd1, SIZE_WORD, BURST_INCR);
    exp_q.push_back(snap_exp[63:32]); resp_q.push_back(RESP_OKAY);
    exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    r_collect(4'h9, 2, 1'b0);

    // Illegal size and WRAP bursts: error beats, full length.
    ar_send(BASE + 32'h0000_BFF8, 4'hA, 8'd1, 3'b001, BURST_INCR);
    exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    r_collect(4'hA, 2, 1'b0);
    ar_send(BASE + 32'h0000_BFF8, 4'hB, 8'd2, SIZE_WORD, BURST_WRAP);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0); resp_q.push_back(RESP_SLVERR);
    end
    r_collect(4'hB, 3, 1'b0);

    // Reset in the middle of a burst.
    ar_send(BASE + 32'h0000_BFF8, 4'hC, 8'd3, SIZE_WORD, BURST_INCR);
    rready = 1'b1;
    check("mid_first_rdata", {32'd0, rdata}, {32'd0, snap_exp[31:0]});
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rready = 1'b0;
    check("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("mid_rst_mtime", mtime, 64'd0);
    check("mid_rst_arready", {63'd0, arready}, 64'd0);
    @(negedge clock);
    check("mid_rst_arready_back", {63'd0, arready}, 64'd1);
    check("mid_rst_rvalid_idle", {63'd0, rvalid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
